// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle, signed or unsigned operands,
// 2*WIDTH-bit exact product with a one-cycle done pulse.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              accept_c;
  logic              last_c;

  logic [CW-1:0]     cnt;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic              neg;

  logic              a_neg_c;
  logic              b_neg_c;
  logic [WIDTH-1:0]  a_mag_c;
  logic [WIDTH-1:0]  b_mag_c;
  logic [PW-1:0]     sum_c;
  logic [PW-1:0]     res_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: accept from IDLE or DONE, run exactly WIDTH cycles
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_c   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned
  always_comb begin
    a_neg_c = signed_mode & a[WIDTH-1];
    b_neg_c = signed_mode & b[WIDTH-1];
    a_mag_c = a_neg_c ? (~a + WIDTH'(1)) : a;
    b_mag_c = b_neg_c ? (~b + WIDTH'(1)) : b;
    sum_c   = acc + (mplier[0] ? mcand : '0);
    res_c   = neg ? (~sum_c + PW'(1)) : sum_c;
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= (state_nx == RUN);
      done <= (state_nx == DONE);
      if (accept_c) begin
        mcand  <= PW'(a_mag_c);
        mplier <= b_mag_c;
        neg    <= a_neg_c ^ b_neg_c;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= sum_c;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last_c) begin
          product <= res_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: WIDTH=8 and WIDTH=16 instances checked against an
// arithmetic reference model with cycle-accurate accept/done timing.
module tb_shift_add_multiplier;

  typedef struct {
    logic [63:0] prod;
    longint      cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        st [2] = '{1'b0, 1'b0};
  logic        sm [2] = '{1'b0, 1'b0};
  logic [31:0] av [2] = '{32'd0, 32'd0};
  logic [31:0] bv [2] = '{32'd0, 32'd0};

  logic        busy8, done8, busy16, done16;
  logic [15:0] p8;
  logic [31:0] p16;

  int          w [2] = '{8, 16};
  int          rem [2] = '{0, 0};
  logic        exp_done [2] = '{1'b0, 1'b0};
  logic [63:0] held [2] = '{64'd0, 64'd0};
  logic [63:0] cur [2] = '{64'd0, 64'd0};
  longint      cyc = 0;
  exp_t        q0 [$];
  exp_t        q1 [$];

  int n_cmp = 0;
  int n_bad = 0;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .busy(busy8), .done(done8), .product(p8)
  );

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
    .a(av[1][15:0]), .b(bv[1][15:0]), .busy(busy16), .done(done16), .product(p16)
  );

  always #5 clk = ~clk;

  // Reference product: plain integer multiply of the interpreted operands, truncated to 2w bits
  function automatic logic [63:0] ref_mul(int wd, logic s, logic [31:0] x, logic [31:0] y);
    longint sx, sy, p;
    logic [31:0] m;
    logic [63:0] mask;
    m    = (32'd1 << wd) - 32'd1;
    mask = (64'd1 << (2 * wd)) - 64'd1;
    sx   = longint'({32'd0, x & m});
    sy   = longint'({32'd0, y & m});
    if (s && x[wd-1]) sx = sx - (longint'(1) << wd);
    if (s && y[wd-1]) sy = sy - (longint'(1) << wd);
    p = sx * sy;
    return 64'(p) & mask;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: accept when idle, done exactly w cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rem[i] = 0;
        exp_done[i] = 1'b0;
        held[i] = 64'd0;
      end
      q0.delete();
      q1.delete();
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        exp_done[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            exp_done[i] = 1'b1;
            held[i] = cur[i];
          end
        end else if (st[i]) begin
          exp_t e;
          cur[i] = ref_mul(w[i], sm[i], av[i], bv[i]);
          rem[i] = w[i];
          e.prod = cur[i];
          e.cyc  = cyc + longint'(w[i]);
          if (i == 0) q0.push_back(e);
          else q1.push_back(e);
        end
      end
    end
  end

  // Monitor: status every cycle, scoreboard pop on each done pulse
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        b_act, d_act;
      logic [63:0] p_act;
      exp_t        e;
      b_act = (i == 0) ? busy8 : busy16;
      d_act = (i == 0) ? done8 : done16;
      p_act = (i == 0) ? {48'd0, p8} : {32'd0, p16};
      check(i == 0 ? "busy8" : "busy16", {63'd0, b_act}, {63'd0, rem[i] > 0});
      check(i == 0 ? "done8" : "done16", {63'd0, d_act}, {63'd0, exp_done[i]});
      check(i == 0 ? "hold8" : "hold16", p_act, held[i]);
      if (d_act === 1'b1) begin
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb%0d: done with empty scoreboard at cycle %0d", w[i], cyc);
        end else begin
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          check(i == 0 ? "prod8" : "prod16", p_act, e.prod);
          check(i == 0 ? "lat8" : "lat16", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic go(int i, logic s, logic [31:0] x, logic [31:0] y);
    @(posedge clk); #1;
    st[i] = 1'b1; sm[i] = s; av[i] = x; bv[i] = y;
    @(posedge clk); #1;
    st[i] = 1'b0;
    repeat (w[i] + 1) @(posedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // First accept on the very first edge after reset release
    st[0] = 1'b1; sm[0] = 1'b0; av[0] = 32'd2; bv[0] = 32'd3;
    rst = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (10) @(posedge clk);

    go(0, 1'b0, 32'hFF, 32'hFF);
    go(0, 1'b0, 32'h0F, 32'hF0);
    go(0, 1'b1, 32'h80, 32'h80);
    go(0, 1'b1, 32'hFF, 32'h01);
    go(0, 1'b1, 32'h00, 32'hFF);
    go(0, 1'b0, 32'h14, 32'hE9);
    go(0, 1'b0, 32'h00, 32'hAB);

    // Start held high: back-to-back multiplies
    @(posedge clk); #1;
    st[0] = 1'b1; sm[0] = 1'b0; av[0] = 32'd3; bv[0] = 32'd5;
    repeat (40) @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (10) @(posedge clk);

    // Start pulse with other operands while busy is ignored
    @(posedge clk); #1;
    st[0] = 1'b1; sm[0] = 1'b1; av[0] = 32'h81; bv[0] = 32'h7F;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 st[0] = 1'b1; sm[0] = 1'b0; av[0] = 32'h01; bv[0] = 32'h01;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (8) @(posedge clk);

    // Reset mid-multiply, then a fresh multiply
    @(posedge clk); #1;
    st[0] = 1'b1; sm[0] = 1'b0; av[0] = 32'hFF; bv[0] = 32'hFF;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    go(0, 1'b0, 32'd2, 32'd3);

    go(1, 1'b0, 32'hFFFF, 32'hFFFF);
    go(1, 1'b1, 32'h8000, 32'h7FFF);
    go(1, 1'b1, 32'h8000, 32'h8000);

    // Random traffic on both instances, including starts while busy
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        st[i] = ($urandom_range(0, 2) == 0);
        sm[i] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: av[i] = 32'd0;
          1: av[i] = 32'hFFFF_FFFF;
          2: av[i] = 32'd1 << (w[i] - 1);
          default: av[i] = $urandom;
        endcase
        bv[i] = ($urandom_range(0, 4) == 0) ? (32'd1 << (w[i] - 1)) : $urandom;
      end
    end
    @(posedge clk); #1;
    st[0] = 1'b0; st[1] = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("drain", 64'(q0.size() + q1.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 Port: signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start.
REQ-006 Port: a  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplier; sampled with start.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; product valid and new.
REQ-010 Port: product  output  2*WIDTH  result of the last completed multiply.

Function
REQ-011 States: IDLE, RUN, DONE; one bit-iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-012 Accept: a start high at a rising edge while in IDLE or DONE latches a, b, signed_mode, clears accumulator and counter, and moves to RUN.
REQ-013 start high while in RUN is ignored; the latched operands are not disturbed.
REQ-014 Operand prep on accept: signed_mode=1 -> latch |a|, |b| as WIDTH-bit unsigned magnitudes, and a negate flag = a[WIDTH-1] XOR b[WIDTH-1]; signed_mode=0 -> latch raw values, negate flag = 0.
REQ-015 |-(2^(WIDTH-1))| is 2^(WIDTH-1), which fits in WIDTH unsigned bits; no overflow or saturation.
REQ-016 RUN: one multiplier bit per cycle, LSB first; if the bit is 1, add the shifted multiplicand into a 2*WIDTH-bit accumulator; carries are never lost.
REQ-017 RUN lasts exactly WIDTH cycles, with no early termination on zero operands.
REQ-018 On the final RUN edge, load product with the accumulator, or its two's-complement negation if the negate flag is set, then go to DONE.
REQ-019 Latency: with accept at edge E0, product updates and done rises at edge E(WIDTH), so done is high for the cycle after E(WIDTH).
REQ-020 busy is 1 in RUN and 0 in IDLE/DONE.
REQ-021 done is 1 only in DONE, for exactly one cycle.
REQ-022 DONE -> RUN if start=1 (back-to-back, zero bubble); otherwise DONE -> IDLE.
REQ-023 product holds its value from the end of one multiply until the final edge of the next; accept does not clear it.
REQ-024 Signed result is exact two's complement over 2*WIDTH bits; unsigned result is exact over 2*WIDTH bits.
REQ-025 Zero product in signed mode with negate flag set is 0, not a negative-zero artefact.

Reset
REQ-026 While rst=1: state=IDLE, counter=0, accumulator=0, product=0, busy=0, done=0, independent of clk.
REQ-027 rst asserted in RUN aborts the operation with no done pulse, and product reads 0 after reset.
REQ-028 First accept is possible at the first rising clk edge after rst deasserts.

Verification
REQ-029 WIDTH=8, unsigned, a=0xFF, b=0xFF, start one cycle -> busy for 8 cycles, done pulse, product=0xFE01.
REQ-030 WIDTH=8, unsigned, a=0x0F, b=0xF0 -> product=0x0E10; then signed, a=0x80, b=0x80 -> product=0x4000; signed a=0xFF, b=0x01 -> product=0xFFFF.
REQ-031 WIDTH=8, start held high continuously with a=3, b=5 -> done every 9 cycles after the first, product=0x000F each time; start pulses during busy leave the result unaffected.
REQ-032 WIDTH=8, a=0x00, b=0xAB, prior product=0x1234 -> product stays 0x1234 until the done edge, then becomes 0x0000.
REQ-033 rst pulsed 3 cycles into a multiply of 0xFF*0xFF -> busy=0, done never pulses, product=0; a new multiply of 2*3 completes to 0x0006.
REQ-034 WIDTH=16, unsigned, 0xFFFF*0xFFFF -> done after 16 cycles, product=0xFFFE0001; signed 0x8000*0x7FFF -> product=0xC0008000.
